// File: rtl/lpddr2_avl_arbiter.sv
// lpddr2_avl_arbiter
// Shares the single LPDDR2 avl_0 port between a write-only requester (W)
// and a read-only requester (R), all in the afi_half_clk domain.
// Arbitration is per command. A write burst keeps its grant until the last
// beat. Outstanding read beats are capped at MAX_PEND. No new grant is given
// while local_init_done is low.
// Build option: define ARB_RD_PRIORITY_EN to let R win whenever eligible.
// W is still forced in after MAX_RD_RUN back-to-back R grants.
// MAX_RD_RUN exists only in that build.
// Without the macro, W and R strictly alternate when both are eligible.
module lpddr2_avl_arbiter #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 32,
  parameter int BURST_W    = 3,
`ifdef ARB_RD_PRIORITY_EN
  parameter int MAX_RD_RUN = 4,
`endif
  parameter int MAX_PEND   = 8
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               local_init_done,
  input  logic               w_write,
  input  logic [ADDR_W-1:0]  w_address,
  input  logic [DATA_W-1:0]  w_writedata,
  input  logic [BURST_W-1:0] w_burstcount,
  output logic               w_waitrequest_n,
  input  logic               r_read,
  input  logic [ADDR_W-1:0]  r_address,
  input  logic [BURST_W-1:0] r_burstcount,
  output logic               r_waitrequest_n,
  output logic [DATA_W-1:0]  r_readdata,
  output logic               r_readdatavalid,
  input  logic               avl_ready,
  output logic               avl_burstbegin,
  output logic [ADDR_W-1:0]  avl_addr,
  output logic [DATA_W-1:0]  avl_wdata,
  output logic               avl_read_req,
  output logic               avl_write_req,
  output logic [BURST_W-1:0] avl_size,
  input  logic               avl_rdata_valid,
  input  logic [DATA_W-1:0]  avl_rdata,
  output logic [7:0]         rd_pending
);

  typedef enum logic [1:0] {IDLE, GNT_W, GNT_R} arb_state_t;

  arb_state_t         state;
  arb_state_t         state_next;
  logic [BURST_W-1:0] w_burst_eff;
  logic [BURST_W-1:0] r_burst_eff;
  logic [BURST_W-1:0] beats_left;
  logic               first_beat;
  logic [8:0]         pend_sum;
  logic               r_eligible;
  logic               grant_w;
  logic               grant_r;
  logic               w_beat_acc;
  logic               w_last_beat;
  logic               r_cmd_acc;
  logic [7:0]         pend_add;
  logic [7:0]         pend_next;

  // A burstcount of zero means a single beat
  assign w_burst_eff = (w_burstcount == '0) ? BURST_W'(1) : w_burstcount;
  assign r_burst_eff = (r_burstcount == '0) ? BURST_W'(1) : r_burstcount;

  // A read may only start if its beats still fit under the outstanding cap
  assign pend_sum   = {1'b0, rd_pending} + 9'(r_burst_eff);
  assign r_eligible = r_read && (pend_sum <= 9'(MAX_PEND));

  assign w_beat_acc  = (state == GNT_W) && w_write && avl_ready;
  assign w_last_beat = w_beat_acc &&
                       (first_beat ? (w_burst_eff == BURST_W'(1)) : (beats_left == BURST_W'(1)));
  assign r_cmd_acc   = (state == GNT_R) && r_read && avl_ready;

`ifdef ARB_RD_PRIORITY_EN
  logic [7:0] rd_run;
  logic       rd_run_full;

  assign rd_run_full = (rd_run >= 8'(MAX_RD_RUN));

  // Pick the winner for the next command: reads first, unless the read run is used up and W waits
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    if (local_init_done) begin
      if (r_eligible && !(w_write && rd_run_full)) begin
        grant_r = 1'b1;
      end else if (w_write) begin
        grant_w = 1'b1;
      end
    end
  end

  // Count back-to-back read grants; any write grant restarts the run
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rd_run <= '0;
    end else if (state == IDLE) begin
      if (grant_w) begin
        rd_run <= '0;
      end else if (grant_r && !rd_run_full) begin
        rd_run <= rd_run + 8'd1;
      end
    end
  end
`else
  logic last_was_w;

  // Pick the winner for the next command: when both are eligible, serve the one not served last
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    if (local_init_done) begin
      if (w_write && r_eligible) begin
        grant_w = !last_was_w;
        grant_r = last_was_w;
      end else begin
        grant_w = w_write;
        grant_r = r_eligible;
      end
    end
  end

  // Remember which requester completed the most recent command
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      last_was_w <= 1'b0;
    end else if (w_last_beat) begin
      last_was_w <= 1'b1;
    end else if (r_cmd_acc) begin
      last_was_w <= 1'b0;
    end
  end
`endif

  // State register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a grant lasts until its write burst ends or its read command is taken
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_w) begin
          state_next = GNT_W;
        end else if (grant_r) begin
          state_next = GNT_R;
        end
      end
      GNT_W: begin
        if (w_last_beat) begin
          state_next = IDLE;
        end
      end
      GNT_R: begin
        if (r_cmd_acc) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Track write beats: the count is loaded from burstcount on the first accepted beat
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      first_beat <= 1'b0;
      beats_left <= '0;
    end else if ((state == IDLE) && grant_w) begin
      first_beat <= 1'b1;
    end else if (w_beat_acc) begin
      first_beat <= 1'b0;
      beats_left <= (first_beat ? w_burst_eff : beats_left) - BURST_W'(1);
    end
  end

  // Outstanding read beats: add on command accept, subtract on each return, never below zero
  always_comb begin
    pend_add  = rd_pending + (r_cmd_acc ? 8'(r_burst_eff) : 8'd0);
    pend_next = pend_add;
    if (avl_rdata_valid && (pend_add != 8'd0)) begin
      pend_next = pend_add - 8'd1;
    end
  end

  // Outstanding read beat register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rd_pending <= '0;
    end else begin
      rd_pending <= pend_next;
    end
  end

  // Route the granted requester to the controller; everything is zero when nobody holds a grant
  always_comb begin
    avl_burstbegin  = 1'b0;
    avl_addr        = '0;
    avl_wdata       = '0;
    avl_read_req    = 1'b0;
    avl_write_req   = 1'b0;
    avl_size        = '0;
    w_waitrequest_n = 1'b0;
    r_waitrequest_n = 1'b0;
    case (state)
      GNT_W: begin
        avl_addr        = w_address;
        avl_wdata       = w_writedata;
        avl_size        = w_burst_eff;
        avl_write_req   = w_write;
        avl_burstbegin  = first_beat && w_write;
        w_waitrequest_n = avl_ready;
      end
      GNT_R: begin
        avl_addr        = r_address;
        avl_size        = r_burst_eff;
        avl_read_req    = r_read;
        avl_burstbegin  = 1'b1;
        r_waitrequest_n = avl_ready;
      end
      default: begin
      end
    endcase
  end

  assign r_readdata      = avl_rdata;
  assign r_readdatavalid = avl_rdata_valid;

endmodule

// File: tb/tb_lpddr2_avl_arbiter.sv
`timescale 1ns/1ps
// Bench for lpddr2_avl_arbiter.
// A directed sequence runs first, followed by a random phase.
// Every cycle is compared against a command-level model of the arbitration rules.
module tb_lpddr2_avl_arbiter;

  localparam int ADDR_W   = 27;
  localparam int DATA_W   = 32;
  localparam int BURST_W  = 3;
  localparam int MAX_PEND = 8;
`ifdef ARB_RD_PRIORITY_EN
  localparam int MAX_RD_RUN = 4;
`endif
  localparam int OWN_NONE = 0;
  localparam int OWN_W    = 1;
  localparam int OWN_R    = 2;

  logic               iCLK = 1'b0;
  logic               iRST_n;
  logic               local_init_done;
  logic               w_write;
  logic [ADDR_W-1:0]  w_address;
  logic [DATA_W-1:0]  w_writedata;
  logic [BURST_W-1:0] w_burstcount;
  logic               w_waitrequest_n;
  logic               r_read;
  logic [ADDR_W-1:0]  r_address;
  logic [BURST_W-1:0] r_burstcount;
  logic               r_waitrequest_n;
  logic [DATA_W-1:0]  r_readdata;
  logic               r_readdatavalid;
  logic               avl_ready;
  logic               avl_burstbegin;
  logic [ADDR_W-1:0]  avl_addr;
  logic [DATA_W-1:0]  avl_wdata;
  logic               avl_read_req;
  logic               avl_write_req;
  logic [BURST_W-1:0] avl_size;
  logic               avl_rdata_valid;
  logic [DATA_W-1:0]  avl_rdata;
  logic [7:0]         rd_pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who owns the port, beats still owed, reads outstanding, fairness history
  int m_owner;
  int m_left;
  int m_pending;
  bit m_first;
`ifdef ARB_RD_PRIORITY_EN
  int m_run;
`else
  bit m_last_w;
`endif

  // Observed events
  int cnt_wbeats  = 0;
  int cnt_wfirst  = 0;
  int cnt_rcmd    = 0;
  int cnt_reqcyc  = 0;
  int cnt_wrncyc  = 0;
  int grant_log[$];
  int ready_pat[5] = '{1, 0, 1, 1, 1};

  always #5 iCLK = ~iCLK;

  lpddr2_avl_arbiter dut (
    .iCLK            (iCLK),
    .iRST_n          (iRST_n),
    .local_init_done (local_init_done),
    .w_write         (w_write),
    .w_address       (w_address),
    .w_writedata     (w_writedata),
    .w_burstcount    (w_burstcount),
    .w_waitrequest_n (w_waitrequest_n),
    .r_read          (r_read),
    .r_address       (r_address),
    .r_burstcount    (r_burstcount),
    .r_waitrequest_n (r_waitrequest_n),
    .r_readdata      (r_readdata),
    .r_readdatavalid (r_readdatavalid),
    .avl_ready       (avl_ready),
    .avl_burstbegin  (avl_burstbegin),
    .avl_addr        (avl_addr),
    .avl_wdata       (avl_wdata),
    .avl_read_req    (avl_read_req),
    .avl_write_req   (avl_write_req),
    .avl_size        (avl_size),
    .avl_rdata_valid (avl_rdata_valid),
    .avl_rdata       (avl_rdata),
    .rd_pending      (rd_pending)
  );

  function automatic int eff(input logic [BURST_W-1:0] b);
    if (b == '0) return 1;
    return int'(b);
  endfunction

  function automatic void modelReset();
    m_owner   = OWN_NONE;
    m_left    = 0;
    m_pending = 0;
    m_first   = 1'b0;
`ifdef ARB_RD_PRIORITY_EN
    m_run     = 0;
`else
    m_last_w  = 1'b0;
`endif
  endfunction

  // Advance the model by one clock using the inputs present at the edge
  function automatic void modelStep();
    int  new_pend;
    bit  acc_rd;
    bit  w_el;
    bit  r_el;
    if (!iRST_n) begin
      modelReset();
      return;
    end
    acc_rd   = (m_owner == OWN_R) && r_read && avl_ready;
    new_pend = m_pending + (acc_rd ? eff(r_burstcount) : 0) - (avl_rdata_valid ? 1 : 0);
    if (new_pend < 0) new_pend = 0;
    if (m_owner == OWN_NONE) begin
      if (local_init_done) begin
        w_el = w_write;
        r_el = r_read && ((m_pending + eff(r_burstcount)) <= MAX_PEND);
`ifdef ARB_RD_PRIORITY_EN
        if (r_el && !(w_el && (m_run >= MAX_RD_RUN))) begin
          m_owner = OWN_R;
          m_run++;
        end else if (w_el) begin
          m_owner = OWN_W;
          m_first = 1'b1;
          m_run   = 0;
        end
`else
        if (w_el && r_el) m_owner = m_last_w ? OWN_R : OWN_W;
        else if (w_el) m_owner = OWN_W;
        else if (r_el) m_owner = OWN_R;
        if (m_owner == OWN_W) m_first = 1'b1;
`endif
      end
    end else if (m_owner == OWN_W) begin
      if (w_write && avl_ready) begin
        if (m_first) begin
          m_left  = eff(w_burstcount);
          m_first = 1'b0;
        end
        m_left--;
        if (m_left == 0) begin
          m_owner = OWN_NONE;
`ifndef ARB_RD_PRIORITY_EN
          m_last_w = 1'b1;
`endif
        end
      end
    end else if (acc_rd) begin
      m_owner = OWN_NONE;
`ifndef ARB_RD_PRIORITY_EN
      m_last_w = 1'b0;
`endif
    end
    m_pending = new_pend;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model says the port should show now
  task automatic checkAll(input string tag);
    logic               e_wr, e_rd, e_bb, e_wwn, e_rwn;
    logic [ADDR_W-1:0]  e_addr;
    logic [DATA_W-1:0]  e_wdata;
    logic [BURST_W-1:0] e_size;
    e_wr = 1'b0; e_rd = 1'b0; e_bb = 1'b0; e_wwn = 1'b0; e_rwn = 1'b0;
    e_addr = '0; e_wdata = '0; e_size = '0;
    if (m_owner == OWN_W) begin
      e_wr    = w_write;
      e_bb    = m_first && w_write;
      e_wwn   = avl_ready;
      e_addr  = w_address;
      e_wdata = w_writedata;
      e_size  = BURST_W'(eff(w_burstcount));
    end else if (m_owner == OWN_R) begin
      e_rd   = r_read;
      e_bb   = 1'b1;
      e_rwn  = avl_ready;
      e_addr = r_address;
      e_size = BURST_W'(eff(r_burstcount));
    end
    checkOutput({tag, ":write_req"},  64'(avl_write_req),   64'(e_wr));
    checkOutput({tag, ":read_req"},   64'(avl_read_req),    64'(e_rd));
    checkOutput({tag, ":burstbegin"}, 64'(avl_burstbegin),  64'(e_bb));
    checkOutput({tag, ":w_wrn"},      64'(w_waitrequest_n), 64'(e_wwn));
    checkOutput({tag, ":r_wrn"},      64'(r_waitrequest_n), 64'(e_rwn));
    checkOutput({tag, ":addr"},       64'(avl_addr),        64'(e_addr));
    checkOutput({tag, ":wdata"},      64'(avl_wdata),       64'(e_wdata));
    checkOutput({tag, ":size"},       64'(avl_size),        64'(e_size));
    checkOutput({tag, ":rd_pending"}, 64'(rd_pending),      64'(m_pending));
    checkOutput({tag, ":readdata"},   64'(r_readdata),      64'(avl_rdata));
    checkOutput({tag, ":rdvalid"},    64'(r_readdatavalid), 64'(avl_rdata_valid));
  endtask

  // Inputs were set just after a falling edge: check, log events, run one clock
  task automatic applyStimulus(input string tag);
    #1;
    if (!iRST_n) modelReset();
    checkAll(tag);
    if (avl_write_req || avl_read_req) cnt_reqcyc++;
    if (w_waitrequest_n || r_waitrequest_n) cnt_wrncyc++;
    if (avl_write_req && avl_ready) begin
      cnt_wbeats++;
      if (avl_burstbegin) begin
        cnt_wfirst++;
        grant_log.push_back(OWN_W);
      end
    end
    if (avl_read_req && avl_ready) begin
      cnt_rcmd++;
      grant_log.push_back(OWN_R);
    end
    @(posedge iCLK);
    modelStep();
    @(negedge iCLK);
  endtask

  // Return every outstanding read beat with no requests active
  task automatic drainReads(input string tag);
    w_write = 1'b0;
    r_read  = 1'b0;
    for (int i = 0; i < 40 && m_pending > 0; i++) begin
      avl_rdata_valid = 1'b1;
      applyStimulus(tag);
    end
    avl_rdata_valid = 1'b0;
    checkOutput({tag, ":drained"}, 64'(rd_pending), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_w;
    int base_f;
    int base_r;
    int base_q;
    int base_n;
    int exp_g;

    iRST_n = 1'b0; local_init_done = 1'b0;
    w_write = 1'b0; w_address = '0; w_writedata = '0; w_burstcount = '0;
    r_read = 1'b0; r_address = '0; r_burstcount = '0;
    avl_ready = 1'b0; avl_rdata_valid = 1'b0; avl_rdata = '0;
    modelReset();
    @(negedge iCLK);

    // Reset state
    repeat (3) applyStimulus("reset");
    checkOutput("reset_rd_pending", 64'(rd_pending), 64'd0);
    checkOutput("reset_w_wrn", 64'(w_waitrequest_n), 64'd0);
    iRST_n = 1'b1;

    // Controller not ready: both requesting for 50 cycles, nothing may be granted
    w_write = 1'b1; w_address = 27'h55; w_burstcount = 3'd1;
    r_read = 1'b1; r_address = 27'h66; r_burstcount = 3'd1; avl_ready = 1'b1;
    base_q = cnt_reqcyc; base_n = cnt_wrncyc;
    repeat (50) applyStimulus("no_init");
    checkOutput("no_init_req", 64'(cnt_reqcyc - base_q), 64'd0);
    checkOutput("no_init_wrn", 64'(cnt_wrncyc - base_n), 64'd0);
    w_write = 1'b0; r_read = 1'b0; local_init_done = 1'b1;
    applyStimulus("init_up");

    // Write burst of 4 at 0x100 with ready 1,0,1,1,1
    base_w = cnt_wbeats; base_f = cnt_wfirst;
    w_write = 1'b1; w_address = 27'h100; w_burstcount = 3'd4;
    w_writedata = 32'hA000_0000; avl_ready = 1'b0;
    applyStimulus("wb_req");
    for (int i = 0; i < 5; i++) begin
      avl_ready = ready_pat[i][0];
      w_writedata = 32'hA000_0000 + 32'(cnt_wbeats - base_w);
      applyStimulus("wb_beat");
    end
    w_write = 1'b0; avl_ready = 1'b1;
    applyStimulus("wb_done");
    checkOutput("wb_beats", 64'(cnt_wbeats - base_w), 64'd4);
    checkOutput("wb_burstbegin_once", 64'(cnt_wfirst - base_f), 64'd1);

    // Reset in the middle of a write burst with reads outstanding
    r_read = 1'b1; r_address = 27'h2000; r_burstcount = 3'd2; avl_ready = 1'b1;
    base_r = cnt_rcmd;
    for (int i = 0; i < 10 && cnt_rcmd == base_r; i++) applyStimulus("rm_rd");
    checkOutput("rm_rd_accept", 64'(cnt_rcmd - base_r), 64'd1);
    r_read = 1'b0;
    checkOutput("rm_pend_before", 64'(rd_pending), 64'd2);
    w_write = 1'b1; w_address = 27'h300; w_burstcount = 3'd4;
    base_w = cnt_wbeats;
    for (int i = 0; i < 10 && cnt_wbeats == base_w; i++) applyStimulus("rm_beat1");
    checkOutput("rm_beat1_seen", 64'(cnt_wbeats - base_w), 64'd1);
    iRST_n = 1'b0; avl_rdata_valid = 1'b1;
    applyStimulus("rm_reset");
    checkOutput("rm_write_req", 64'(avl_write_req), 64'd0);
    checkOutput("rm_burstbegin", 64'(avl_burstbegin), 64'd0);
    checkOutput("rm_w_wrn", 64'(w_waitrequest_n), 64'd0);
    checkOutput("rm_pending", 64'(rd_pending), 64'd0);
    iRST_n = 1'b1; w_write = 1'b0;
    repeat (2) applyStimulus("rm_late_return");
    avl_rdata_valid = 1'b0;
    checkOutput("rm_no_underflow", 64'(rd_pending), 64'd0);

    // Both requesting single beats: grant order over 8 commands
    w_write = 1'b1; w_burstcount = 3'd1; w_address = 27'h400;
    r_read = 1'b1; r_burstcount = 3'd1; r_address = 27'h500; avl_ready = 1'b1;
    grant_log.delete();
    for (int i = 0; i < 200 && grant_log.size() < 8; i++) begin
      avl_rdata_valid = (m_pending > 0);
      applyStimulus("alt");
    end
    checkOutput("alt_enough_grants", 64'(grant_log.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef ARB_RD_PRIORITY_EN
      exp_g = ((i % 5) == 4) ? OWN_W : OWN_R;
`else
      exp_g = ((i % 2) == 0) ? OWN_W : OWN_R;
`endif
      checkOutput($sformatf("alt_grant%0d", i), 64'(grant_log[i]), 64'(exp_g));
    end
    drainReads("alt_drain");

    // Read bursts of 4 with no returns: two fit, the third waits for 4 returns
    r_read = 1'b1; r_burstcount = 3'd4; r_address = 27'h4000; avl_ready = 1'b1;
    base_r = cnt_rcmd;
    repeat (20) applyStimulus("pend_fill");
    checkOutput("pend_two_cmds", 64'(cnt_rcmd - base_r), 64'd2);
    checkOutput("pend_full", 64'(rd_pending), 64'd8);
    avl_rdata_valid = 1'b1;
    repeat (4) applyStimulus("pend_ret");
    avl_rdata_valid = 1'b0;
    checkOutput("pend_after_ret", 64'(rd_pending), 64'd4);
    checkOutput("pend_still_two", 64'(cnt_rcmd - base_r), 64'd2);
    repeat (10) applyStimulus("pend_third");
    checkOutput("pend_three_cmds", 64'(cnt_rcmd - base_r), 64'd3);
    checkOutput("pend_full_again", 64'(rd_pending), 64'd8);
    drainReads("pend_drain");

    // Random traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      local_init_done = ($urandom_range(0, 19) != 0);
      if (w_write) w_write = ($urandom_range(0, 9) != 0);
      else         w_write = ($urandom_range(0, 2) == 0);
      if (r_read)  r_read  = ($urandom_range(0, 9) != 0);
      else         r_read  = ($urandom_range(0, 2) == 0);
      w_address       = ADDR_W'($urandom);
      w_writedata     = $urandom;
      w_burstcount    = BURST_W'($urandom_range(0, 7));
      r_address       = ADDR_W'($urandom);
      r_burstcount    = BURST_W'($urandom_range(0, 7));
      avl_ready       = ($urandom_range(0, 3) != 0);
      avl_rdata_valid = (m_pending > 0) && ($urandom_range(0, 2) == 0);
      avl_rdata       = $urandom;
      applyStimulus("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
